// File: rtl/vx_commit_tx_pkg.sv
// Widths and commit packet layout shared by the commit transmit slice.
package vx_commit_tx_pkg;

  localparam int NUM_THREADS = 8;
  localparam int XLEN        = 32;
  localparam int UUID_WIDTH  = 8;
  localparam int NW_WIDTH    = 2;
  localparam int CU_WIS_W    = 2;
  localparam int PC_BITS     = 16;
  localparam int NR_BITS     = 5;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]       uuid;
    logic [NW_WIDTH-1:0]         wid;
    logic [CU_WIS_W-1:0]         cu_id;
    logic [PC_BITS-1:0]          pc;
    logic                        wb;
    logic [NR_BITS-1:0]          rd;
    logic [NUM_THREADS-1:0]      tmask;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic                        sop;
    logic                        eop;
  } commit_t;

  localparam int DATAW = $bits(commit_t);

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_commit_tx_if.sv
// Full-width commit packet handshake between the commit slice and its consumer.
interface vx_commit_tx_if;
  import vx_commit_tx_pkg::*;

  logic    valid;
  logic    ready;
  commit_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/vx_commit_tx_fifo.sv
// Small circular output queue; storage is deliberately left out of reset.
module vx_commit_tx_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [DATAW-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  assign data_out = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/vx_commit_tx.sv
// Gathers NUM_LANES-wide result slices into a full-width commit packet and
// queues finished packets for the commit interface.
module vx_commit_tx
  import vx_commit_tx_pkg::*;
#(
  parameter int CORE_ID   = 0,
  parameter int NUM_LANES = 4,
  parameter int OUT_DEPTH = 2,
  localparam int PID_COUNT = NUM_THREADS / NUM_LANES,
  localparam int PID_WIDTH = clog2_min1(PID_COUNT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [UUID_WIDTH-1:0]     in_uuid,
  input  logic [NW_WIDTH-1:0]       in_wid,
  input  logic [CU_WIS_W-1:0]       in_cu_id,
  input  logic [PC_BITS-1:0]        in_PC,
  input  logic                      in_wb,
  input  logic [NR_BITS-1:0]        in_rd,
  input  logic [NUM_LANES-1:0]      in_tmask,
  input  logic [NUM_LANES*XLEN-1:0] in_data,
  input  logic [PID_WIDTH-1:0]      in_pid,
  input  logic                      in_sop,
  input  logic                      in_eop,
  vx_commit_tx_if.master            commit_if,
  output logic                      pid_err
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  if (NUM_THREADS % NUM_LANES != 0) begin : g_bad_lanes
    $error("vx_commit_tx: NUM_LANES must divide NUM_THREADS");
  end
  if (OUT_DEPTH < 2) begin : g_bad_depth
    $error("vx_commit_tx: OUT_DEPTH must be at least 2");
  end
  if (CORE_ID < 0) begin : g_bad_core
    $error("vx_commit_tx: CORE_ID must be non-negative");
  end

  logic                 fire;
  logic                 pid_last;
  logic                 push;
  logic                 pop;
  logic [PID_WIDTH-1:0] exp_pid;
  int                   lane_base;
  commit_t              gather_q;
  commit_t              gather_d;
  logic [DATAW-1:0]     fifo_dout;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  assign fire      = in_valid && in_ready;
  assign pid_last  = (PID_COUNT == 1) || (in_pid == PID_WIDTH'(PID_COUNT - 1));
  assign push      = fire && pid_last;
  assign pop       = commit_if.valid && commit_if.ready;
  assign lane_base = int'(in_pid) * NUM_LANES;

  // The pushed packet merges the current slice, so the last beat lands in the same cycle.
  always_comb begin
    gather_d = gather_q;
    gather_d.tmask[lane_base +: NUM_LANES]           = in_tmask;
    gather_d.data[lane_base*XLEN +: NUM_LANES*XLEN]  = in_data;
    if (in_pid == '0) begin
      gather_d.uuid  = in_uuid;
      gather_d.wid   = in_wid;
      gather_d.cu_id = in_cu_id;
      gather_d.pc    = in_PC;
      gather_d.wb    = in_wb;
      gather_d.rd    = in_rd;
      gather_d.sop   = in_sop;
      gather_d.eop   = in_eop;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) gather_q <= gather_d;
  end

  // Counter follows the accepted pid, which also resynchronises after a misordered slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_pid  <= '0;
      pid_err  <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      pid_err  <= fire && (in_pid != exp_pid);
      if (fire) exp_pid <= pid_last ? '0 : in_pid + PID_WIDTH'(1);
      in_ready <= (fifo_count < CNT_W'(OUT_DEPTH - 1))
               || ((fifo_count < CNT_W'(OUT_DEPTH)) && !push);
    end
  end

  vx_commit_tx_fifo #(
    .DATAW (DATAW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (gather_d),
    .data_out (fifo_dout),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign commit_if.valid = !fifo_empty;
  assign commit_if.data  = commit_t'(fifo_dout);

endmodule

// File: tb/tb_vx_commit_tx.sv
// Directed bench for vx_commit_tx: 8 threads gathered from two 4-lane slices.
module tb_vx_commit_tx;
  import vx_commit_tx_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [UUID_WIDTH-1:0] in_uuid;
  logic [NW_WIDTH-1:0]   in_wid;
  logic [CU_WIS_W-1:0]   in_cu_id;
  logic [PC_BITS-1:0]    in_PC;
  logic                  in_wb;
  logic [NR_BITS-1:0]    in_rd;
  logic [3:0]            in_tmask;
  logic [127:0]          in_data;
  logic [0:0]            in_pid;
  logic                  in_sop;
  logic                  in_eop;
  logic                  pid_err;

  int      checks   = 0;
  int      errors   = 0;
  int      perr_cnt = 0;
  bit      done;
  commit_t got_q[$];

  vx_commit_tx_if cif ();

  vx_commit_tx #(.CORE_ID(0), .NUM_LANES(4), .OUT_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_uuid(in_uuid), .in_wid(in_wid), .in_cu_id(in_cu_id), .in_PC(in_PC),
    .in_wb(in_wb), .in_rd(in_rd), .in_tmask(in_tmask), .in_data(in_data),
    .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
    .commit_if(cif), .pid_err(pid_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset === 1'b0 && cif.valid === 1'b1 && cif.ready === 1'b1) got_q.push_back(cif.data);
    if (reset === 1'b0 && pid_err === 1'b1) perr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] mkdata(input logic [7:0] u, input logic p);
    logic [127:0] d;
    for (int l = 0; l < 4; l++) d[l*32 +: 32] = {u, 7'd0, p, 8'(l), 8'hC3 ^ u};
    return d;
  endfunction

  function automatic commit_t exp_pkt(input logic [7:0] u, input logic s, input logic e,
                                      input logic [7:0] tm);
    commit_t p;
    p.uuid  = u;
    p.wid   = u[1:0];
    p.cu_id = u[3:2];
    p.pc    = {8'h80, u};
    p.wb    = u[0];
    p.rd    = u[4:0];
    p.tmask = tm;
    p.data  = {mkdata(u, 1'b1), mkdata(u, 1'b0)};
    p.sop   = s;
    p.eop   = e;
    return p;
  endfunction

  function automatic logic [3:0] s5_tm0(input int i);
    return (i == 2) ? 4'h0 : 4'(i + 1);
  endfunction

  function automatic logic [3:0] s5_tm1(input int i);
    return (i == 2) ? 4'h0 : (4'hF ^ 4'(i));
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [3:0] tm, input logic [7:0] hu,
                       input logic [7:0] du, input logic s, input logic e);
    in_valid = 1'b1;
    in_pid   = p;
    in_tmask = tm;
    in_data  = mkdata(du, p);
    in_uuid  = hu;
    in_wid   = hu[1:0];
    in_cu_id = hu[3:2];
    in_PC    = {8'h80, hu};
    in_wb    = hu[0];
    in_rd    = hu[4:0];
    in_sop   = s;
    in_eop   = e;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic p, input logic [3:0] tm, input logic [7:0] hu,
                      input logic [7:0] du, input logic s, input logic e);
    int n = 0;
    drive(p, tm, hu, du, s, e);
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept", 512'(in_ready), 512'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int n);
    int k = 0;
    while (got_q.size() < n && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("pkt_count", 512'(got_q.size()), 512'(n));
  endtask

  task automatic pop_chk(input string tag, input commit_t e);
    commit_t g = '0;
    if (got_q.size() > 0) g = got_q.pop_front();
    chk(tag, 512'(g), 512'(e));
  endtask

  initial begin
    commit_t pj;
    int      base;

    reset     = 1'b1;
    cif.ready = 1'b0;
    drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    in_valid  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", 512'(in_ready), 512'(1'b1));
    chk("rst_valid",    512'(cif.valid), 512'(1'b0));
    chk("rst_pid_err",  512'(pid_err), 512'(1'b0));

    // basic gather, latency 1, header/sop/eop taken from pid0 beat
    cif.ready = 1'b1;
    send(1'b0, 4'b1011, 8'h11, 8'h11, 1'b1, 1'b1);
    chk("s1_no_early_valid", 512'(cif.valid), 512'(1'b0));
    send(1'b1, 4'b0001, 8'hEE, 8'h11, 1'b0, 1'b0);
    chk("s1_valid_lat1", 512'(cif.valid), 512'(1'b1));
    chk("s1_data", 512'(cif.data), 512'(exp_pkt(8'h11, 1'b1, 1'b1, 8'b0001_1011)));
    @(negedge clk);
    chk("s1_valid_drop", 512'(cif.valid), 512'(1'b0));
    wait_pkts(1);
    pop_chk("s1_pkt", exp_pkt(8'h11, 1'b1, 1'b1, 8'b0001_1011));

    // backpressure: two packets fill the queue, third stalls
    cif.ready = 1'b0;
    send(1'b0, 4'hF, 8'h21, 8'h21, 1'b1, 1'b1);
    send(1'b1, 4'hF, 8'h21, 8'h21, 1'b1, 1'b1);
    send(1'b0, 4'h3, 8'h22, 8'h22, 1'b1, 1'b1);
    send(1'b1, 4'hC, 8'h22, 8'h22, 1'b1, 1'b1);
    drive(1'b0, 4'h5, 8'h23, 8'h23, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("s2_in_ready_low", 512'(in_ready), 512'(1'b0));
    chk("s2_head_stable", 512'(cif.data), 512'(exp_pkt(8'h21, 1'b1, 1'b1, 8'hFF)));
    chk("s2_none_popped", 512'(got_q.size()), 512'(0));
    cif.ready = 1'b1;
    send(1'b0, 4'h5, 8'h23, 8'h23, 1'b1, 1'b1);
    send(1'b1, 4'hA, 8'h23, 8'h23, 1'b1, 1'b1);
    wait_pkts(3);
    pop_chk("s2_pkt1", exp_pkt(8'h21, 1'b1, 1'b1, 8'hFF));
    pop_chk("s2_pkt2", exp_pkt(8'h22, 1'b1, 1'b1, 8'b1100_0011));
    pop_chk("s2_pkt3", exp_pkt(8'h23, 1'b1, 1'b1, 8'b1010_0101));
    repeat (2) @(negedge clk);
    chk("s2_in_ready_back", 512'(in_ready), 512'(1'b1));

    // out-of-order first slice
    base = perr_cnt;
    send(1'b1, 4'h9, 8'h30, 8'h30, 1'b1, 1'b1);
    chk("s3_pid_err_pulse", 512'(pid_err), 512'(1'b1));
    send(1'b0, 4'h6, 8'h31, 8'h31, 1'b1, 1'b1);
    chk("s3_pid_err_clear", 512'(pid_err), 512'(1'b0));
    send(1'b1, 4'h7, 8'h31, 8'h31, 1'b1, 1'b1);
    wait_pkts(2);
    pj = '0;
    if (got_q.size() > 0) pj = got_q.pop_front();
    chk("s3_stray_slice", 512'(pj.tmask[7:4]), 512'(4'h9));
    pop_chk("s3_pkt", exp_pkt(8'h31, 1'b1, 1'b1, 8'b0111_0110));
    chk("s3_err_count", 512'(perr_cnt - base), 512'(1));

    // reset in the middle of a gather
    base = perr_cnt;
    send(1'b0, 4'hF, 8'h44, 8'h44, 1'b1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("s4_valid_after_rst", 512'(cif.valid), 512'(1'b0));
    chk("s4_ready_after_rst", 512'(in_ready), 512'(1'b1));
    send(1'b0, 4'h1, 8'h45, 8'h45, 1'b1, 1'b1);
    send(1'b1, 4'h8, 8'h45, 8'h45, 1'b1, 1'b1);
    wait_pkts(1);
    pop_chk("s4_pkt", exp_pkt(8'h45, 1'b1, 1'b1, 8'b1000_0001));
    chk("s4_no_pid_err", 512'(perr_cnt - base), 512'(0));

    // streaming with consumer ready toggling; packet 2 has an all-zero mask
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(1'b0, s5_tm0(i), 8'(8'h50 + i), 8'(8'h50 + i), 1'b1, 1'b1);
          send(1'b1, s5_tm1(i), 8'(8'h50 + i), 8'(8'h50 + i), 1'b1, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          cif.ready = ~cif.ready;
        end
      end
    join
    cif.ready = 1'b1;
    wait_pkts(6);
    for (int i = 0; i < 6; i++)
      pop_chk("s5_pkt", exp_pkt(8'(8'h50 + i), 1'b1, 1'b1, {s5_tm1(i), s5_tm0(i)}));

    // multi-packet instruction flags
    send(1'b0, 4'hF, 8'h61, 8'h61, 1'b1, 1'b0);
    send(1'b1, 4'hF, 8'h61, 8'h61, 1'b1, 1'b0);
    send(1'b0, 4'h3, 8'h62, 8'h62, 1'b0, 1'b1);
    send(1'b1, 4'h3, 8'h62, 8'h62, 1'b0, 1'b1);
    wait_pkts(2);
    pop_chk("s6_first", exp_pkt(8'h61, 1'b1, 1'b0, 8'hFF));
    pop_chk("s6_last",  exp_pkt(8'h62, 1'b0, 1'b1, 8'h33));

    repeat (4) @(negedge clk);
    chk("end_queue_empty", 512'(got_q.size()), 512'(0));
    chk("end_pid_err_total", 512'(perr_cnt - base), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
